// File: rtl/msgbuf_pkg.sv
// Shared constants and state encoding for the message buffer that feeds the
// compression round datapath.
package msgbuf_pkg;

   localparam int WORDS_DEF  = 16;
   localparam int ROUNDS_DEF = 64;
   localparam int WORD_W     = 32;
   localparam int IDX_W      = 4;
   localparam int ROUND_W    = 6;
   localparam int DEPTH      = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/msgbuf.sv
// Message word buffer: collects one block of words, then steps the round
// counter for the external index lookup and serves word[idx_i] combinationally.
module msgbuf
   import msgbuf_pkg::*;
#(
   parameter int WORDS  = WORDS_DEF,
   parameter int ROUNDS = ROUNDS_DEF
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               wvalid_i,
   input  logic [WORD_W-1:0]  wdata_i,
   output logic               wready_o,
   input  logic               flush_i,
   input  logic               adv_i,
   input  logic [IDX_W-1:0]   idx_i,
   output logic [ROUND_W-1:0] round_o,
   output logic [WORD_W-1:0]  m_o,
   output logic               run_o,
   output logic               done_o
);

   localparam logic [IDX_W-1:0]   LAST_CNT   = IDX_W'(WORDS - 1);
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

   state_t               state_r;
   state_t               state_s;
   logic [IDX_W-1:0]     cnt_r;
   logic [IDX_W-1:0]     cnt_s;
   logic [ROUND_W-1:0]   round_r;
   logic [ROUND_W-1:0]   round_s;
   logic                 we_s;
   logic [WORD_W-1:0]    words_r [DEPTH];

   // Next-state, counters and write enable; flush overrides everything.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      round_s = round_r;
      we_s    = 1'b0;
      if (flush_i) begin
         state_s = ST_IDLE;
         cnt_s   = '0;
         round_s = '0;
      end else begin
         case (state_r)
            ST_IDLE, ST_LOAD: begin
               if (wvalid_i) begin
                  we_s = 1'b1;
                  if (cnt_r == LAST_CNT) begin
                     state_s = ST_RUN;
                     cnt_s   = '0;
                     round_s = '0;
                  end else begin
                     state_s = ST_LOAD;
                     cnt_s   = cnt_r + 4'd1;
                  end
               end else begin
                  state_s = state_r;
               end
            end
            ST_RUN: begin
               if (adv_i) begin
                  if (round_r == LAST_ROUND) begin
                     state_s = ST_DONE;
                  end else begin
                     round_s = round_r + 6'd1;
                  end
               end else begin
                  round_s = round_r;
               end
            end
            ST_DONE: begin
               state_s = ST_IDLE;
               round_s = '0;
            end
            default: begin
               state_s = ST_IDLE;
               cnt_s   = '0;
               round_s = '0;
            end
         endcase
      end
   end

   // FSM state and counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         round_r <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         round_r <= round_s;
      end
   end

   // Word store; contents survive flush and are cleared only by reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            words_r[i] <= '0;
         end
      end else if (we_s) begin
         words_r[cnt_r] <= wdata_i;
      end
   end

   assign wready_o = (state_r == ST_IDLE) || (state_r == ST_LOAD);
   assign run_o    = (state_r == ST_RUN);
   assign done_o   = (state_r == ST_DONE);
   assign round_o  = round_r;
   assign m_o      = words_r[idx_i];

endmodule

// File: tb/tb_msgbuf.sv
// Self-checking bench for msgbuf: directed scenarios plus randomized traffic
// checked against a block-level reference model.
module tb_msgbuf;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        wvalid_i;
   logic [31:0] wdata_i;
   logic        wready_o;
   logic        flush_i;
   logic        adv_i;
   logic [3:0]  idx_i;
   logic [5:0]  round_o;
   logic [31:0] m_o;
   logic        run_o;
   logic        done_o;

   int tests_run = 0;
   int fails     = 0;
   int accepts   = 0;

   // reference model: filling a block, running rounds, or signalling done
   localparam int PH_FILL = 0;
   localparam int PH_RUN  = 1;
   localparam int PH_DONE = 2;
   int          m_phase;
   int          m_filled;
   int          m_rnd;
   logic [31:0] m_mem [16];

   msgbuf dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .wvalid_i(wvalid_i),
      .wdata_i (wdata_i),
      .wready_o(wready_o),
      .flush_i (flush_i),
      .adv_i   (adv_i),
      .idx_i   (idx_i),
      .round_o (round_o),
      .m_o     (m_o),
      .run_o   (run_o),
      .done_o  (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic model_reset();
      m_phase  = PH_FILL;
      m_filled = 0;
      m_rnd    = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;
   endtask

   task automatic model_step();
      if (!rst_ni) begin
         model_reset();
      end else if (flush_i) begin
         m_phase  = PH_FILL;
         m_filled = 0;
         m_rnd    = 0;
      end else if (m_phase == PH_FILL) begin
         if (wvalid_i) begin
            m_mem[m_filled] = wdata_i;
            m_filled++;
            if (m_filled == 16) begin
               m_phase  = PH_RUN;
               m_filled = 0;
               m_rnd    = 0;
            end
         end
      end else if (m_phase == PH_RUN) begin
         if (adv_i) begin
            if (m_rnd == 63) m_phase = PH_DONE;
            else m_rnd++;
         end
      end else begin
         m_phase = PH_FILL;
         m_rnd   = 0;
      end
   endtask

   task automatic tick();
      if (wvalid_i && wready_o && rst_ni) accepts++;
      model_step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic load_block(input logic [31:0] base, input int nwords, input bit gaps);
      for (int k = 0; k < nwords; k++) begin
         wvalid_i = 1'b1;
         wdata_i  = base + 32'(k);
         tick();
         if (gaps && k >= 7 && k < nwords - 1) begin
            wvalid_i = 1'b0;
            wdata_i  = 32'hBAD0_0000 + 32'(k);
            repeat (3) tick();
         end
      end
      wvalid_i = 1'b0;
   endtask

   task automatic advance(input int n);
      adv_i = 1'b1;
      repeat (n) tick();
      adv_i = 1'b0;
   endtask

   task automatic test_reset_state();
      idx_i = 4'd9;
      #1;
      tests_run++;
      if ({wready_o, run_o, done_o, round_o, m_o} !== {1'b1, 1'b0, 1'b0, 6'd0, 32'd0}) begin
         fails++;
         $display("FAIL reset_state: got wready=%b run=%b done=%b round=%0d m=%h, want 1 0 0 0 0",
                  wready_o, run_o, done_o, round_o, m_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_load();
      accepts = 0;
      load_block(32'h1000_0000, 16, 1'b1);
      tests_run++;
      if (accepts !== 16) begin
         fails++;
         $display("FAIL load_accepts: got %0d, want 16", accepts);
      end
      idx_i = 4'd5;
      #1;
      tests_run++;
      if ({run_o, wready_o, round_o, m_o} !== {1'b1, 1'b0, 6'd0, 32'h1000_0005}) begin
         fails++;
         $display("FAIL load_enter_run: got run=%b wready=%b round=%0d m=%h, want 1 0 0 10000005",
                  run_o, wready_o, round_o, m_o);
      end
      // a word offered during RUN must not land in the store
      wvalid_i = 1'b1;
      wdata_i  = 32'hDEAD_BEEF;
      tick();
      wvalid_i = 1'b0;
      idx_i    = 4'd0;
      #1;
      tests_run++;
      if (m_o !== 32'h1000_0000) begin
         fails++;
         $display("FAIL ignore_wvalid_in_run: got m=%h, want 10000000", m_o);
      end
   endtask

   task automatic test_stall();
      logic [5:0] exp_seq [5];
      logic       adv_seq [4];
      exp_seq = '{6'd10, 6'd11, 6'd11, 6'd11, 6'd12};
      adv_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
      advance(10);
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (round_o !== exp_seq[i]) begin
            fails++;
            $display("FAIL stall_round[%0d]: got %0d, want %0d", i, round_o, exp_seq[i]);
         end
         if (i < 4) begin
            adv_i = adv_seq[i];
            tick();
         end
      end
      adv_i = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      idx_i = 4'd5;
      #3;
      rst_ni = 1'b0;
      #1;
      tests_run++;
      if ({wready_o, run_o, done_o, round_o, m_o} !== {1'b1, 1'b0, 1'b0, 6'd0, 32'd0}) begin
         fails++;
         $display("FAIL reset_mid_run: got wready=%b run=%b done=%b round=%0d m=%h, want 1 0 0 0 0",
                  wready_o, run_o, done_o, round_o, m_o);
      end
      model_reset();
      tick();
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_run();
      int dones = 0;
      load_block(32'h2000_0000, 16, 1'b0);
      adv_i = 1'b1;
      for (int k = 0; k < 64; k++) begin
         tests_run++;
         if ({run_o, round_o, done_o} !== {1'b1, 6'(k), 1'b0}) begin
            fails++;
            $display("FAIL run_round[%0d]: got run=%b round=%0d done=%b, want 1 %0d 0",
                     k, run_o, round_o, done_o, k);
         end
         tick();
      end
      adv_i = 1'b0;
      tests_run++;
      if ({done_o, run_o, round_o, wready_o} !== {1'b1, 1'b0, 6'd63, 1'b0}) begin
         fails++;
         $display("FAIL run_done: got done=%b run=%b round=%0d wready=%b, want 1 0 63 0",
                  done_o, run_o, round_o, wready_o);
      end
      tick();
      tests_run++;
      if ({done_o, wready_o, round_o} !== {1'b0, 1'b1, 6'd0}) begin
         fails++;
         $display("FAIL run_after_done: got done=%b wready=%b round=%0d, want 0 1 0",
                  done_o, wready_o, round_o);
      end
      for (int i = 0; i < 3; i++) begin
         if (done_o) dones++;
         tick();
      end
      tests_run++;
      if (dones !== 0) begin
         fails++;
         $display("FAIL done_single_pulse: got %0d extra pulses, want 0", dones);
      end
   endtask

   task automatic test_flush();
      int dones = 0;
      load_block(32'h3000_0000, 16, 1'b0);
      advance(20);
      tests_run++;
      if (round_o !== 6'd20) begin
         fails++;
         $display("FAIL flush_pre_round: got %0d, want 20", round_o);
      end
      flush_i = 1'b1;
      adv_i   = 1'b1;
      tick();
      flush_i = 1'b0;
      adv_i   = 1'b0;
      idx_i   = 4'd3;
      #1;
      tests_run++;
      if ({wready_o, run_o, done_o, round_o, m_o} !== {1'b1, 1'b0, 1'b0, 6'd0, 32'h3000_0003}) begin
         fails++;
         $display("FAIL flush_at_20: got wready=%b run=%b done=%b round=%0d m=%h, want 1 0 0 0 30000003",
                  wready_o, run_o, done_o, round_o, m_o);
      end
      // flush coinciding with the final advance
      load_block(32'h3000_0000, 16, 1'b0);
      advance(63);
      tests_run++;
      if (round_o !== 6'd63) begin
         fails++;
         $display("FAIL flush_pre_63: got %0d, want 63", round_o);
      end
      flush_i = 1'b1;
      adv_i   = 1'b1;
      tick();
      flush_i = 1'b0;
      adv_i   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (done_o || run_o) dones++;
         tick();
      end
      tests_run++;
      if ({dones, wready_o, round_o} !== {32'd0, 1'b1, 6'd0}) begin
         fails++;
         $display("FAIL flush_at_63: got done/run cycles=%0d wready=%b round=%0d, want 0 1 0",
                  dones, wready_o, round_o);
      end
   endtask

   task automatic test_flush_accept();
      load_block(32'h4000_0000, 8, 1'b0);
      wvalid_i = 1'b1;
      wdata_i  = 32'h4000_0008;
      flush_i  = 1'b1;
      tick();
      flush_i  = 1'b0;
      wvalid_i = 1'b0;
      idx_i    = 4'd8;
      #1;
      tests_run++;
      if ({wready_o, m_o} !== {1'b1, 32'h3000_0008}) begin
         fails++;
         $display("FAIL flush_accept_discard: got wready=%b m=%h, want 1 30000008", wready_o, m_o);
      end
      load_block(32'h55AA_0000, 1, 1'b0);
      idx_i = 4'd0;
      #1;
      tests_run++;
      if (m_o !== 32'h55AA_0000) begin
         fails++;
         $display("FAIL flush_accept_cnt0: got m=%h, want 55aa0000", m_o);
      end
      load_block(32'h6600_0001, 14, 1'b0);
      tests_run++;
      if ({run_o, wready_o} !== {1'b0, 1'b1}) begin
         fails++;
         $display("FAIL flush_accept_15: got run=%b wready=%b, want 0 1", run_o, wready_o);
      end
      load_block(32'h6600_000F, 1, 1'b0);
      tests_run++;
      if (run_o !== 1'b1) begin
         fails++;
         $display("FAIL flush_accept_16: got run=%b, want 1", run_o);
      end
   endtask

   task automatic test_random();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         wvalid_i = ($urandom_range(0, 1) == 0);
         wdata_i  = $urandom;
         adv_i    = ($urandom_range(0, 3) != 0);
         flush_i  = ($urandom_range(0, 199) == 0);
         tick();
         idx_i = 4'($urandom_range(0, 15));
         #1;
         tests_run++;
         if ({wready_o, run_o, done_o, round_o, m_o} !==
             {(m_phase == PH_FILL), (m_phase == PH_RUN), (m_phase == PH_DONE), 6'(m_rnd), m_mem[idx_i]}) begin
            fails++;
            $display("FAIL random[%0d]: got wready=%b run=%b done=%b round=%0d m=%h, want phase=%0d round=%0d m=%h",
                     c, wready_o, run_o, done_o, round_o, m_o, m_phase, m_rnd, m_mem[idx_i]);
         end
      end
      wvalid_i = 1'b0;
      adv_i    = 1'b0;
      flush_i  = 1'b0;
   endtask

   initial begin
      rst_ni   = 1'b0;
      wvalid_i = 1'b0;
      wdata_i  = 32'd0;
      flush_i  = 1'b0;
      adv_i    = 1'b0;
      idx_i    = 4'd0;
      model_reset();
      repeat (2) @(posedge clk_i);
      test_reset_state();
      test_load();
      test_stall();
      test_reset_mid_run();
      test_run();
      test_flush();
      test_flush_accept();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/msgbuf.md
MSGBUF -- requirements
Module: msgbuf

Interface
REQ-001 Parameter WORDS, default 16, is the number of 32-bit message words per block.
REQ-002 Parameter ROUNDS, default 64, is the number of compression rounds per block.
REQ-003 clk_i  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 wvalid_i  input  1  marks a valid message word on wdata_i.
REQ-006 wdata_i  input  32  carries the message word; the first accepted word is word 0.
REQ-007 wready_o  output  1  means the buffer accepts a word this cycle.
REQ-008 flush_i  input  1  is a synchronous abort back to IDLE.
REQ-009 adv_i  input  1  is the round-advance strobe from the compression datapath.
REQ-010 idx_i  input  4  is the message word index returned by the message-index lookup block for round_o.
REQ-011 round_o  output  6  is the current round, 0-63, driven to the message-index lookup block.
REQ-012 m_o  output  32  is the stored word selected by idx_i.
REQ-013 run_o  output  1  is high while rounds are in progress.
REQ-014 done_o  output  1  is a one-cycle pulse marking block completion.

Function
REQ-015 The block SHALL implement the FSM states IDLE, LOAD, RUN and DONE.
REQ-016 A word SHALL be accepted only on a cycle where wvalid_i and wready_o are both high.
REQ-017 wready_o SHALL be 1 in IDLE and LOAD and 0 in RUN and DONE.
REQ-018 Each accepted word SHALL be written to word[cnt], after which the 4-bit cnt increments.
REQ-019 The first accept in IDLE SHALL move the FSM to LOAD.
REQ-020 The accept with cnt=15 SHALL move the FSM to RUN and set cnt=0 and round=0.
REQ-021 A WORDS=1 build SHALL go directly from IDLE to RUN.
REQ-022 Cycles with wvalid_i low SHALL leave cnt and the FSM unchanged, so gaps are allowed.
REQ-023 In RUN, run_o SHALL be 1 and round_o SHALL equal the round counter.
REQ-024 adv_i high in RUN SHALL increment the round counter by 1.
REQ-025 adv_i low in RUN SHALL hold the round counter.
REQ-026 adv_i with round=63 SHALL move the FSM to DONE without wrapping; round_o SHALL read 63 during DONE.
REQ-027 DONE SHALL last exactly one cycle with done_o=1, then the FSM SHALL return to IDLE with round=0.
REQ-028 m_o SHALL be combinational, equal to word[idx_i] in every state, with zero latency from idx_i.
REQ-029 adv_i outside RUN SHALL be ignored.
REQ-030 wvalid_i outside IDLE/LOAD SHALL be ignored, and the word SHALL NOT be written.
REQ-031 flush_i in any state SHALL move the FSM to IDLE next cycle with cnt=0 and round=0.
REQ-032 On flush, stored words SHALL be retained and done_o SHALL NOT pulse.
REQ-033 If flush_i and a word accept coincide, flush_i SHALL win and the word SHALL be discarded.
REQ-034 If flush_i and adv_i coincide at round 63, flush_i SHALL win and no done_o SHALL be produced.

Reset
REQ-035 rst_ni low SHALL immediately force the FSM to IDLE, cnt=0, round=0 and all words to 0.
REQ-036 During and after reset the outputs SHALL be wready_o=1, run_o=0, done_o=0, round_o=0 and m_o=0.
REQ-037 Reset SHALL take effect in any state, including mid-LOAD and mid-RUN, with no partial completion.

Structure
REQ-038 WORDS, ROUNDS, the state encodings and the round/index widths SHALL live in the shared defines header.
REQ-039 No sub-module is needed: the message-index lookup block SHALL stay external, connected via round_o/idx_i.
REQ-040 The word store SHALL be 16x32 flops with a 16:1 read mux.

Verification
REQ-041 Reset scenario: assert rst_ni=0 mid-RUN -> immediately wready_o=1, run_o=0, round_o=0 and m_o=0.
REQ-042 Load scenario: stream words 0x10000000+k for k=0..15 with wvalid_i gaps of 3 cycles after k=7 -> exactly 16 accepts, then run_o=1 and round_o=0; idx_i=5 -> m_o=0x10000005.
REQ-043 Run scenario: hold adv_i=1 -> round_o steps 0..63 on consecutive cycles; done_o pulses for one cycle after the advance at 63; next cycle wready_o=1.
REQ-044 Stall scenario: toggle adv_i 1,0,0,1 from round 10 -> round_o reads 10, 11, 11, 11, 12.
REQ-045 Flush scenario: flush_i at round 20 -> next cycle IDLE, round_o=0 and no done_o.
REQ-046 Flush-with-accept scenario: flush_i together with the 9th accept -> cnt=0 and the word is not written.
